// File: rtl/sha2_stream_core_pkg.sv
// sha2_stream_core_pkg: SHA-2 types, FSM states, K/IV constants and round helper functions
package sha2_stream_core_pkg;
  typedef logic [31:0] word_t;
  typedef logic [7:0][31:0] hv_t;
  typedef logic [15:0][31:0] win_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_UPD, S_OUT} state_t;
  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam word_t IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam word_t IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  function automatic word_t ror(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
  function automatic word_t sum0(input word_t x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic word_t sum1(input word_t x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic word_t sig0(input word_t x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic word_t sig1(input word_t x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha2_stream_core_if.sv
// sha2_stream_core_if: control, message-in and digest-out stream signals; master = host, slave = core
interface sha2_stream_core_if;
  import sha2_stream_core_pkg::*;
  logic start, mode, in_valid, in_ready, in_last, busy, out_valid, out_ready, out_last, err;
  word_t in_data, out_data;
  modport master (output start, mode, in_valid, in_data, in_last, out_ready,
                  input in_ready, busy, out_valid, out_data, out_last, err);
  modport slave (input start, mode, in_valid, in_data, in_last, out_ready,
                 output in_ready, busy, out_valid, out_data, out_last, err);
endinterface

// File: rtl/sha2_stream_core_round.sv
// sha2_stream_core_round: one combinational SHA-2 round plus message-window shift; i_s/i_w/i_k in, o_s/o_w out
module sha2_stream_core_round
  import sha2_stream_core_pkg::*;
(
  input  hv_t   i_s,
  input  win_t  i_w,
  input  word_t i_k,
  output hv_t   o_s,
  output win_t  o_w
);
  word_t w_t1, w_t2;
  assign w_t1 = i_s[7] + sum1(i_s[4]) + ch(i_s[4], i_s[5], i_s[6]) + i_k + i_w[0];
  assign w_t2 = sum0(i_s[0]) + maj(i_s[0], i_s[1], i_s[2]);
  assign o_s = {i_s[6:4], i_s[3] + w_t1, i_s[2:0], w_t1 + w_t2};
  assign o_w = {sig1(i_w[14]) + i_w[9] + sig0(i_w[1]) + i_w[0], i_w[15:1]};
endmodule

// File: rtl/sha2_stream_core.sv
// sha2_stream_core: multi-block SHA-224/256 streaming core; ports clk, rst, bus (slave: start/mode, in stream, out stream, busy, err)
module sha2_stream_core
  import sha2_stream_core_pkg::*;
#(
  parameter int UNROLL    = 1,
  parameter bit EN_SHA224 = 1
)
(
  input logic clk,
  input logic rst,
  sha2_stream_core_if.slave bus
);
  state_t r_state;
  hv_t r_h, r_s;
  win_t r_w;
  word_t r_out_data;
  logic [3:0] r_wcnt;
  logic [5:0] r_rcnt;
  logic [2:0] r_ocnt;
  logic r_mode, r_last_blk, r_in_ready, r_busy, r_out_valid, r_out_last, r_err;
  logic w_mode;
  logic [2:0] w_final, w_onxt;
  assign w_mode = EN_SHA224 && bus.mode;
  assign w_final = r_mode ? 3'd6 : 3'd7;
  assign w_onxt = r_ocnt + 3'd1;
  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    hv_t w_si, w_so;
    win_t w_wi, w_wo;
    if (i == 0) begin : g_head
      assign w_si = r_s;
      assign w_wi = r_w;
    end else begin : g_tail
      assign w_si = g_rnd[i-1].w_so;
      assign w_wi = g_rnd[i-1].w_wo;
    end
    sha2_stream_core_round u_rnd (.i_s(w_si), .i_w(w_wi), .i_k(K[r_rcnt + 6'(i)]), .o_s(w_so), .o_w(w_wo));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_h <= '0;
      r_s <= '0;
      r_w <= '0;
      r_out_data <= '0;
      r_wcnt <= '0;
      r_rcnt <= '0;
      r_ocnt <= '0;
      r_mode <= 1'b0;
      r_last_blk <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last <= 1'b0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          r_mode <= w_mode;
          for (int i = 0; i < 8; i++) r_h[i] <= w_mode ? IV224[i] : IV256[i];
          r_err <= 1'b0;
          r_wcnt <= '0;
          r_in_ready <= 1'b1;
          r_busy <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: if (bus.in_valid) begin
          if (bus.in_last && r_wcnt != 4'd15) begin
            r_err <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_w[r_wcnt] <= bus.in_data;
            r_wcnt <= r_wcnt + 4'd1;
            if (r_wcnt == 4'd15) begin
              r_last_blk <= bus.in_last;
              r_s <= r_h;
              r_rcnt <= '0;
              r_in_ready <= 1'b0;
              r_state <= S_COMP;
            end
          end
        end
        S_COMP: begin
          r_s <= g_rnd[UNROLL-1].w_so;
          r_w <= g_rnd[UNROLL-1].w_wo;
          r_rcnt <= r_rcnt + 6'(UNROLL);
          if (r_rcnt == 6'(64 - UNROLL)) r_state <= S_UPD;
        end
        S_UPD: begin
          for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_s[i];
          r_ocnt <= '0;
          r_out_data <= r_h[0] + r_s[0];
          r_out_valid <= r_last_blk;
          r_out_last <= 1'b0;
          r_in_ready <= !r_last_blk;
          r_state <= r_last_blk ? S_OUT : S_LOAD;
        end
        S_OUT: if (bus.out_ready) begin
          if (r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last <= 1'b0;
            r_busy <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_ocnt <= w_onxt;
            r_out_data <= r_h[w_onxt];
            r_out_last <= w_onxt == w_final;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.in_ready = r_in_ready;
  assign bus.busy = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.out_last = r_out_last;
  assign bus.err = r_err;
endmodule

// File: tb/tb_sha2_stream_core.sv
// tb_sha2_stream_core: directed bench for sha2_stream_core at UNROLL 1, 2 and 4 against known FIPS 180-4 digests
module tb_sha2_stream_core;
  logic clk = 0, rst = 1, start = 0, mode = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  int sel = 0, cyc = 0, checks = 0, errors = 0, t_first = 0, t_out = 0, got_n = 0;
  bit stable;
  logic [31:0] msg [32];
  logic [31:0] exp_d [8];
  logic [31:0] got [16];
  logic glast [16];
  logic rdy, busy, ov, ol, err;
  logic [31:0] od;
  logic [31:0] d_abc256 [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [31:0] d_abc224 [8] = '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                                32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h0};
  logic [31:0] d_two [8] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                             32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  logic [31:0] two_blk1 [16] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  sha2_stream_core_if b0 (), b1 (), b2 ();
  sha2_stream_core #(.UNROLL(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  sha2_stream_core #(.UNROLL(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
  sha2_stream_core #(.UNROLL(4)) u2 (.clk(clk), .rst(rst), .bus(b2));
  assign b0.start = start && sel == 0;
  assign b1.start = start && sel == 1;
  assign b2.start = start && sel == 2;
  assign b0.in_valid = in_valid && sel == 0;
  assign b1.in_valid = in_valid && sel == 1;
  assign b2.in_valid = in_valid && sel == 2;
  assign b0.out_ready = out_ready && sel == 0;
  assign b1.out_ready = out_ready && sel == 1;
  assign b2.out_ready = out_ready && sel == 2;
  assign {b0.mode, b1.mode, b2.mode} = {3{mode}};
  assign {b0.in_last, b1.in_last, b2.in_last} = {3{in_last}};
  assign b0.in_data = in_data;
  assign b1.in_data = in_data;
  assign b2.in_data = in_data;
  assign rdy = sel == 0 ? b0.in_ready : sel == 1 ? b1.in_ready : b2.in_ready;
  assign busy = sel == 0 ? b0.busy : sel == 1 ? b1.busy : b2.busy;
  assign ov = sel == 0 ? b0.out_valid : sel == 1 ? b1.out_valid : b2.out_valid;
  assign ol = sel == 0 ? b0.out_last : sel == 1 ? b1.out_last : b2.out_last;
  assign err = sel == 0 ? b0.err : sel == 1 ? b1.err : b2.err;
  assign od = sel == 0 ? b0.out_data : sel == 1 ? b1.out_data : b2.out_data;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 32; i++) msg[i] = 32'h0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic set_two();
    for (int i = 0; i < 32; i++) msg[i] = i < 16 ? two_blk1[i] : 32'h0;
    msg[31] = 32'h000001c0;
  endtask

  task automatic do_start(input logic m);
    @(negedge clk);
    start = 1;
    mode = m;
    @(negedge clk);
    start = 0;
    mode = 0;
  endtask

  task automatic send_words(input int n, input bit gaps, input int last_at);
    int i = 0, guard = 0;
    while (i < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = msg[i];
      in_last = (i == last_at);
      if (in_valid && rdy) begin
        if (i == 0) t_first = cyc;
        i++;
      end
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
    chk("words_sent", i, n);
  endtask

  task automatic collect(input bit stall);
    int guard = 0, hold = 0;
    bit seen = 0, done = 0;
    logic [31:0] prev = 0;
    got_n = 0;
    stable = 1;
    out_ready = !stall;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (ov) begin
        if (!seen) begin
          seen = 1;
          t_out = cyc;
        end
        if (hold > 0 && od !== prev) stable = 0;
        if (!stall || hold == 5) begin
          out_ready = 1;
          hold = 0;
          if (got_n < 16) begin
            got[got_n] = od;
            glast[got_n] = ol;
          end
          got_n++;
          done = ol;
        end else begin
          out_ready = 0;
          hold++;
        end
        prev = od;
      end
    end
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic verify(input string tag, input int n, input int lat);
    chk($sformatf("%s after_last_valid", tag), ov, 0);
    chk($sformatf("%s after_last_busy", tag), busy, 0);
    chk($sformatf("%s word_count", tag), got_n, n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s data[%0d]", tag, k), got[k], exp_d[k]);
      chk($sformatf("%s last[%0d]", tag, k), glast[k], k == n - 1);
    end
    if (lat > 0) chk($sformatf("%s first_word_to_first_out", tag), t_out - t_first, lat);
  endtask

  initial begin
    int no_out;
    repeat (3) @(negedge clk);
    chk("reset in_ready", rdy, 0);
    chk("reset busy", busy, 0);
    chk("reset out_valid", ov, 0);
    chk("reset out_last", ol, 0);
    chk("reset err", err, 0);
    chk("reset out_data", od, 0);
    rst = 0;
    // SHA-256 "abc"; a stray start with mode=1 during compression must be ignored
    set_abc();
    exp_d = d_abc256;
    do_start(0);
    chk("abc256 busy", busy, 1);
    chk("abc256 in_ready", rdy, 1);
    send_words(16, 0, 15);
    @(negedge clk);
    start = 1;
    mode = 1;
    @(negedge clk);
    start = 0;
    mode = 0;
    collect(0);
    verify("abc256", 8, 81);
    // SHA-224 "abc"
    exp_d = d_abc224;
    do_start(1);
    send_words(16, 0, 15);
    collect(0);
    verify("abc224", 7, 81);
    // two-block message on each unroll factor
    set_two();
    exp_d = d_two;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_start(0);
      send_words(32, 0, 31);
      collect(0);
      verify($sformatf("two_u%0d", 1 << s), 8, 2 * (17 + (64 >> s)));
    end
    sel = 0;
    // input gaps and output backpressure
    do_start(0);
    send_words(32, 1, 31);
    collect(1);
    verify("two_stall", 8, 0);
    chk("two_stall data_stable", stable, 1);
    // in_last on word 5
    do_start(0);
    send_words(6, 0, 5);
    chk("early_last err", err, 1);
    chk("early_last busy", busy, 0);
    chk("early_last in_ready", rdy, 0);
    no_out = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov) no_out++;
    end
    chk("early_last no_out_valid", no_out, 0);
    set_abc();
    exp_d = d_abc256;
    do_start(0);
    chk("restart err_cleared", err, 0);
    send_words(16, 0, 15);
    collect(0);
    verify("after_err", 8, 81);
    // reset in the middle of compression
    do_start(0);
    send_words(16, 0, 15);
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst in_ready", rdy, 0);
    chk("midrst busy", busy, 0);
    chk("midrst out_valid", ov, 0);
    chk("midrst out_last", ol, 0);
    chk("midrst err", err, 0);
    chk("midrst out_data", od, 0);
    rst = 0;
    do_start(0);
    send_words(16, 0, 15);
    collect(0);
    verify("after_rst", 8, 81);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
